// File: rtl/mdu_iter_if.sv
// EX-stage <-> iterative multiply/divide unit connection.
// The EX side is the master and the arithmetic unit is the slave.
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             cancel;
  logic [2:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] hi_i;
  logic [WIDTH-1:0] lo_i;
  logic             busy;
  logic             ready;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             div_by_zero;

  modport master (
    output start, cancel, op, opa, opb, hi_i, lo_i,
    input  busy, ready, result_hi, result_lo, div_by_zero
  );

  modport slave (
    input  start, cancel, op, opa, opb, hi_i, lo_i,
    output busy, ready, result_hi, result_lo, div_by_zero
  );
endinterface

// File: rtl/mdu_iter.sv
// Radix-2 iterative MULT/DIV/MADD/MSUB unit, signed and unsigned, one bit per cycle.
// Signed operands are reduced to magnitudes up front and the signs are fixed in a single FIX cycle.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  mdu_iter_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state_reg, state_next;
  logic               busy_reg, busy_next;
  logic               ready_reg, ready_next;
  logic [2:0]         op_reg;
  logic               sa_reg, sb_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] addend_reg;
  logic [WIDTH-1:0]   res_hi_reg, res_lo_reg;
  logic               dbz_reg;

  logic               signed_in, is_div_in, accept, div0_in;
  logic [WIDTH-1:0]   opa_mag, opb_mag;
  logic               is_div_reg;
  logic [2*WIDTH-1:0] acc_mul;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               q_bit;
  logic [2*WIDTH-1:0] acc_div;
  logic               unused_div_bits;
  logic [2*WIDTH-1:0] prod_fix, mac_fix, fix_res;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign signed_in = ~bus.op[0];
  assign is_div_in = (bus.op[2:1] == 2'b01);
  assign accept    = (state_reg == IDLE) && bus.start && !bus.cancel;
  assign div0_in   = accept && is_div_in && (bus.opb == '0);
  // Negating the most negative value wraps to 2^(W-1), which is exactly its unsigned magnitude.
  assign opa_mag   = (signed_in && bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
  assign opb_mag   = (signed_in && bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;
  assign is_div_reg = (op_reg[2:1] == 2'b01);

  // Multiply step: mcand_reg already carries the shift for this multiplier bit.
  assign acc_mul = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  // Restoring divide step on {remainder, dividend/quotient}; mplier_reg holds the divisor.
  assign div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
  assign div_diff  = {1'b0, div_shift} - {2'b00, mplier_reg};
  assign q_bit     = ~div_diff[WIDTH+1];
  assign acc_div   = {(q_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      acc_reg[WIDTH-2:0], q_bit};
  // The partial remainder is always below the divisor, so these top bits are never needed.
  assign unused_div_bits = div_diff[WIDTH] ^ div_shift[WIDTH];

  always_comb begin
    prod_fix = (sa_reg ^ sb_reg) ? -acc_reg : acc_reg;
    mac_fix  = op_reg[1] ? (addend_reg - prod_fix) : (addend_reg + prod_fix);
    quo_fix  = (sa_reg ^ sb_reg) ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    rem_fix  = sa_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    if (is_div_reg)
      fix_res = {rem_fix, quo_fix};
    else if (op_reg[2])
      fix_res = mac_fix;
    else
      fix_res = prod_fix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= busy_next;
      ready_reg <= ready_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (bus.cancel) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (bus.start) state_next = (is_div_in && bus.opb == '0) ? DONE : RUN;
        RUN:     if (cnt_reg == CW'(WIDTH - 1)) state_next = FIX;
        FIX:     state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_next  = (state_next == RUN) || (state_next == FIX);
    ready_next = (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg     <= '0;
      sa_reg     <= 1'b0;
      sb_reg     <= 1'b0;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      addend_reg <= '0;
      res_hi_reg <= '0;
      res_lo_reg <= '0;
      dbz_reg    <= 1'b0;
    end else begin
      if (accept) begin
        op_reg     <= bus.op;
        sa_reg     <= signed_in & bus.opa[WIDTH-1];
        sb_reg     <= signed_in & bus.opb[WIDTH-1];
        cnt_reg    <= '0;
        addend_reg <= {bus.hi_i, bus.lo_i};
        mplier_reg <= opb_mag;
        if (is_div_in) begin
          acc_reg   <= {{WIDTH{1'b0}}, opa_mag};
          mcand_reg <= '0;
        end else begin
          acc_reg   <= '0;
          mcand_reg <= {{WIDTH{1'b0}}, opa_mag};
        end
        if (div0_in) begin
          res_hi_reg <= bus.opa;
          res_lo_reg <= '1;
          dbz_reg    <= 1'b1;
        end
      end else if (state_reg == RUN && !bus.cancel) begin
        cnt_reg <= cnt_reg + CW'(1);
        if (is_div_reg) begin
          acc_reg <= acc_div;
        end else begin
          acc_reg    <= acc_mul;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
        end
      end else if (state_reg == FIX && !bus.cancel) begin
        res_hi_reg <= fix_res[2*WIDTH-1:WIDTH];
        res_lo_reg <= fix_res[WIDTH-1:0];
        dbz_reg    <= 1'b0;
      end
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.ready       = ready_reg;
  assign bus.result_hi   = res_hi_reg;
  assign bus.result_lo   = res_lo_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter at WIDTH=32 and WIDTH=8: drivers queue expected results,
// negedge monitors pop and compare on every ready pulse.
module tb_mdu_iter;
  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mdu_iter_if #(.WIDTH(32)) bus32 ();
  mdu_iter_if #(.WIDTH(8))  bus8 ();

  mdu_iter #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  mdu_iter #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

  typedef struct {
    int          id;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
    int          busy;
    int unsigned c0;
  } exp_t;

  exp_t sb32[$];
  exp_t sb8[$];
  exp_t e32, e8;
  int   busy_cnt32 = 0;
  int   busy_cnt8  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitors
  always @(negedge clk) begin
    if (!rst) begin
      if (bus32.ready) begin
        if (sb32.size() == 0) begin
          check("dut32 unexpected ready", 64'd1, 64'd0);
        end else begin
          e32 = sb32.pop_front();
          $display("dut32 op%0d hi=%h lo=%h dbz=%0d lat=%0d busy=%0d", e32.id,
                   bus32.result_hi, bus32.result_lo, bus32.div_by_zero,
                   int'(cyc - e32.c0) + 1, busy_cnt32);
          check($sformatf("dut32 op%0d hi", e32.id), 64'(bus32.result_hi), 64'(e32.hi));
          check($sformatf("dut32 op%0d lo", e32.id), 64'(bus32.result_lo), 64'(e32.lo));
          check($sformatf("dut32 op%0d dbz", e32.id), 64'(bus32.div_by_zero), 64'(e32.dbz));
          check($sformatf("dut32 op%0d latency", e32.id), 64'(int'(cyc - e32.c0) + 1), 64'(e32.lat));
          check($sformatf("dut32 op%0d busy cycles", e32.id), 64'(busy_cnt32), 64'(e32.busy));
        end
        busy_cnt32 = 0;
      end else if (bus32.busy) busy_cnt32++;
      else busy_cnt32 = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus8.ready) begin
        if (sb8.size() == 0) begin
          check("dut8 unexpected ready", 64'd1, 64'd0);
        end else begin
          e8 = sb8.pop_front();
          $display("dut8 op%0d hi=%h lo=%h dbz=%0d lat=%0d busy=%0d", e8.id,
                   bus8.result_hi, bus8.result_lo, bus8.div_by_zero,
                   int'(cyc - e8.c0) + 1, busy_cnt8);
          check($sformatf("dut8 op%0d hi", e8.id), 64'(bus8.result_hi), 64'(e8.hi));
          check($sformatf("dut8 op%0d lo", e8.id), 64'(bus8.result_lo), 64'(e8.lo));
          check($sformatf("dut8 op%0d dbz", e8.id), 64'(bus8.div_by_zero), 64'(e8.dbz));
          check($sformatf("dut8 op%0d latency", e8.id), 64'(int'(cyc - e8.c0) + 1), 64'(e8.lat));
          check($sformatf("dut8 op%0d busy cycles", e8.id), 64'(busy_cnt8), 64'(e8.busy));
        end
        busy_cnt8 = 0;
      end else if (bus8.busy) busy_cnt8++;
      else busy_cnt8 = 0;
    end
  end

  // Drivers
  task automatic issue32(input int id, input logic [2:0] op, input logic [31:0] a, b, h, l,
                         input logic [31:0] ehi, elo, input logic edbz,
                         input int elat, ebusy, input bit push);
    exp_t e;
    @(negedge clk);
    bus32.op = op; bus32.opa = a; bus32.opb = b; bus32.hi_i = h; bus32.lo_i = l;
    bus32.start = 1'b1;
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
    if (push) begin
      e.id = id; e.hi = ehi; e.lo = elo; e.dbz = edbz;
      e.lat = elat; e.busy = ebusy; e.c0 = cyc;
      sb32.push_back(e);
    end
  endtask

  task automatic issue8(input int id, input logic [2:0] op, input logic [7:0] a, b, h, l,
                        input logic [7:0] ehi, elo, input logic edbz,
                        input int elat, ebusy);
    exp_t e;
    @(negedge clk);
    bus8.op = op; bus8.opa = a; bus8.opb = b; bus8.hi_i = h; bus8.lo_i = l;
    bus8.start = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    e.id = id; e.hi = 32'(ehi); e.lo = 32'(elo); e.dbz = edbz;
    e.lat = elat; e.busy = ebusy; e.c0 = cyc;
    sb8.push_back(e);
  endtask

  task automatic wait32(input int max_cycles);
    for (int i = 0; i < max_cycles && sb32.size() != 0; i++) @(negedge clk);
    if (sb32.size() != 0) begin
      check("dut32 ready timeout", 64'(sb32.size()), 64'd0);
      sb32.delete();
    end
  endtask

  task automatic wait8(input int max_cycles);
    for (int i = 0; i < max_cycles && sb8.size() != 0; i++) @(negedge clk);
    if (sb8.size() != 0) begin
      check("dut8 ready timeout", 64'(sb8.size()), 64'd0);
      sb8.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus32.start = 0; bus32.cancel = 0; bus32.op = 0; bus32.opa = 0; bus32.opb = 0;
    bus32.hi_i = 0; bus32.lo_i = 0;
    bus8.start = 0; bus8.cancel = 0; bus8.op = 0; bus8.opa = 0; bus8.opb = 0;
    bus8.hi_i = 0; bus8.lo_i = 0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(bus32.busy), 64'd0);
    check("reset ready", 64'(bus32.ready), 64'd0);
    check("reset dbz", 64'(bus32.div_by_zero), 64'd0);
    check("reset hi", 64'(bus32.result_hi), 64'd0);
    check("reset lo", 64'(bus32.result_lo), 64'd0);
    check("reset dut8 busy", 64'(bus8.busy), 64'd0);
    rst = 1'b0;

    // id, op, opa, opb, hi_i, lo_i, exp hi, exp lo, dbz, latency, busy cycles
    issue32(1, 3'b000, 32'hFFFFFFFD, 32'd5, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 34, 33, 1);
    wait32(60);
    issue32(2, 3'b010, 32'hFFFFFFF9, 32'd2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34, 33, 1);
    wait32(60);
    issue32(3, 3'b011, 32'd100, 32'd7, 0, 0, 32'd2, 32'd14, 0, 34, 33, 1);
    wait32(60);
    issue32(4, 3'b011, 32'h12345678, 32'd0, 0, 0, 32'h12345678, 32'hFFFFFFFF, 1, 1, 0, 1);
    wait32(10);
    issue32(5, 3'b101, 32'd2, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd3, 0, 34, 33, 1);
    wait32(60);
    issue32(6, 3'b010, 32'd7, 32'hFFFFFFFE, 0, 0, 32'd1, 32'hFFFFFFFD, 0, 34, 33, 1);
    wait32(60);
    issue32(7, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 32'h00000001, 0, 34, 33, 1);
    wait32(60);
    issue32(8, 3'b100, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 34, 33, 1);
    wait32(60);
    issue32(9, 3'b111, 32'd2, 32'd3, 32'd1, 32'd0, 32'd0, 32'hFFFFFFFA, 0, 34, 33, 1);
    wait32(60);
    // {0,10} - 12 = -2 over the full 64-bit HI:LO pair
    issue32(10, 3'b110, 32'd3, 32'd4, 32'd0, 32'd10, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 34, 33, 1);
    wait32(60);

    // Flush mid-multiply: no completion, previous results kept.
    issue32(11, 3'b000, 32'd9, 32'd9, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (9) @(negedge clk);
    bus32.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus32.cancel = 1'b0;
    check("cancel busy", 64'(bus32.busy), 64'd0);
    check("cancel keeps hi", 64'(bus32.result_hi), 64'hFFFFFFFF);
    check("cancel keeps lo", 64'(bus32.result_lo), 64'hFFFFFFFE);
    issue32(12, 3'b001, 32'd7, 32'd6, 0, 0, 32'd0, 32'h2A, 0, 34, 33, 1);
    wait32(60);

    // cancel together with start in IDLE must not start anything
    @(negedge clk);
    bus32.op = 3'b000; bus32.opa = 32'd5; bus32.opb = 32'd5;
    bus32.start = 1'b1; bus32.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus32.start = 1'b0; bus32.cancel = 1'b0;
    check("cancel+start busy", 64'(bus32.busy), 64'd0);
    repeat (40) @(negedge clk);
    check("cancel+start results kept", {bus32.result_hi, bus32.result_lo}, 64'h2A);

    issue8(1, 3'b000, 8'h80, 8'h80, 0, 0, 8'h40, 8'h00, 0, 10, 9);
    wait8(30);
    issue8(2, 3'b010, 8'h80, 8'hFF, 0, 0, 8'h00, 8'h80, 0, 10, 9);
    wait8(30);
    issue8(3, 3'b011, 8'd200, 8'd13, 0, 0, 8'd5, 8'd15, 0, 10, 9);
    wait8(30);
    issue8(4, 3'b010, 8'h9C, 8'h00, 0, 0, 8'h9C, 8'hFF, 1, 1, 0);
    wait8(10);

    // Reset in the middle of an operation clears results.
    issue32(13, 3'b000, 32'd3, 32'd3, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midop reset busy", 64'(bus32.busy), 64'd0);
    check("midop reset results", {bus32.result_hi, bus32.result_lo}, 64'd0);
    check("midop reset dut8 results", 64'({bus8.result_hi, bus8.result_lo, 7'd0, bus8.div_by_zero}), 64'd0);
    repeat (40) @(negedge clk);
    check("midop reset no ready", 64'(bus32.ready), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
